// File: rtl/hwpe_stream_package.sv
// rtl/hwpe_stream_package.sv - shared types and constants for the hwpe stream realigner
package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_DATA_WIDTH    = 32;
    localparam int unsigned HWPE_STREAM_REALIGN_BYTES = HWPE_STREAM_DATA_WIDTH / 8;
    localparam int unsigned HWPE_STREAM_LINE_W        = 16;

    typedef enum logic {
        RLN_PRIME  = 1'b0,
        RLN_STREAM = 1'b1
    } realign_state_e;

    typedef struct packed {
        logic                          realign;
        logic [HWPE_STREAM_LINE_W-1:0] line_length;
    } ctrl_realign_t;

endpackage

// File: rtl/hwpe_stream_funnel_shift.sv
// rtl/hwpe_stream_funnel_shift.sv - byte selector returning the low word of {hi,lo} >> 8*off
module hwpe_stream_funnel_shift #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OFF_W      = 2
) (
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    input  logic [OFF_W-1:0]      off_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [2*DATA_WIDTH-1:0] cat;

    always_comb begin
        cat    = {hi_i, lo_i};
        data_o = '0;
        for (int b = 0; b < int'(NB); b++) begin
            data_o[8*b +: 8] = cat[8*(b + int'(off_i)) +: 8];
        end
    end

endmodule

// File: rtl/hwpe_stream_line_realigner.sv
// rtl/hwpe_stream_line_realigner.sv - rebuilds byte-aligned words from word-aligned fetches, one line at a time
module hwpe_stream_line_realigner
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH = HWPE_STREAM_DATA_WIDTH,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned LINE_W     = HWPE_STREAM_LINE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  realign_i,
    input  logic [LINE_W-1:0]     line_length_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [STRB_WIDTH-1:0] in_strb_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [STRB_WIDTH-1:0] out_strb_o,
    output logic                  line_done_o
);

    localparam int unsigned OFF_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;

    realign_state_e        state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [LINE_W-1:0]     cnt_q, cnt_d;
    ctrl_realign_t         ctrl_q, ctrl_d;
    logic                  line_done_q, line_done_d;

    logic                  realign_mode;
    logic [LINE_W-1:0]     len_sel, len_eff, cnt_inc;
    logic [DATA_WIDTH-1:0] funnel_data;
    logic                  unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // Lowest strobed byte of the first beat is where the line really starts.
    function automatic logic [OFF_W-1:0] first_byte(input logic [STRB_WIDTH-1:0] s);
        logic [OFF_W-1:0] r;
        r = '0;
        for (int i = int'(STRB_WIDTH) - 1; i >= 0; i--) begin
            if (s[i]) r = OFF_W'(i);
        end
        return r;
    endfunction

    hwpe_stream_funnel_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (OFF_W)
    ) i_funnel (
        .hi_i   (in_data_i),
        .lo_i   (hold_q),
        .off_i  (off_q),
        .data_o (funnel_data)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        line_done_d = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = in_data_i;
        out_strb_o  = in_strb_i;

        // Mode and length are frozen for the duration of a realigned line.
        realign_mode = (state_q == RLN_STREAM) ? ctrl_q.realign : realign_i;
        len_sel      = (state_q == RLN_STREAM) ? LINE_W'(ctrl_q.line_length) : line_length_i;
        len_eff      = (len_sel == '0) ? LINE_W'(1) : len_sel;
        cnt_inc      = cnt_q + LINE_W'(1);

        if (!realign_mode) begin
            out_valid_o = in_valid_i & enable_i;
            in_ready_o  = out_ready_i & enable_i;
            if (in_valid_i && out_ready_i && enable_i) begin
                if (cnt_inc >= len_eff) begin
                    cnt_d       = '0;
                    line_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end else if (state_q == RLN_PRIME) begin
            in_ready_o = enable_i;
            out_strb_o = '1;
            if (in_valid_i && enable_i) begin
                hold_d             = in_data_i;
                off_d              = first_byte(in_strb_i);
                cnt_d              = '0;
                ctrl_d.realign     = realign_i;
                ctrl_d.line_length = HWPE_STREAM_LINE_W'(line_length_i);
                state_d            = RLN_STREAM;
            end
        end else begin
            out_valid_o = in_valid_i & enable_i;
            in_ready_o  = out_ready_i & enable_i;
            out_data_o  = funnel_data;
            out_strb_o  = '1;
            if (in_valid_i && out_ready_i && enable_i) begin
                hold_d = in_data_i;
                cnt_d  = cnt_inc;
                if (cnt_inc >= len_eff) begin
                    state_d     = RLN_PRIME;
                    line_done_d = 1'b1;
                end
            end
        end

        if (clear_i) begin
            state_d     = RLN_PRIME;
            hold_d      = '0;
            off_d       = '0;
            cnt_d       = '0;
            ctrl_d      = '0;
            line_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RLN_PRIME;
            hold_q      <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            ctrl_q      <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            line_done_q <= line_done_d;
        end
    end

    assign line_done_o = line_done_q;

endmodule
